// File: rtl/fetch_unit.sv
// fetch_unit: RV32 fetch stage (PC, IMEM read, IF/ID register, stall/redirect bubbles).
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        misalign_err
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);
  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;
  state_t state;
  logic [31:0] pc;
  assign imem_addr = pc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
      pc <= RESET_PC;
      instr <= NOP_INSTR;
      instr_pc <= RESET_PC;
      instr_valid <= 1'b0;
      misalign_err <= 1'b0;
    end else if (redirect) begin
      state <= RUN;
      pc <= {redirect_pc[31:2], 2'b00};
      instr <= NOP_INSTR;
      instr_valid <= 1'b0;
      misalign_err <= misalign_err | (|redirect_pc[1:0]);
    end else if (state == BOOT) begin
      state <= RUN;
    end else if (stall) begin
      state <= HOLD;
    end else begin
      state <= RUN;
      pc <= pc + 32'd4;
      instr <= imem_rdata;
      instr_pc <= pc;
      instr_valid <= 1'b1;
    end
  end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      stall_cnt <= stall_cnt + {31'd0, stall & ~redirect};
      flush_cnt <= flush_cnt + {31'd0, redirect};
    end
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a behavioural model.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;
  logic        stall = 1'b0, redirect = 1'b0, instr_valid, misalign_err;
  logic [31:0] key = 32'd0;
`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, m_scnt, m_fcnt;
`endif
  logic [31:0] m_pc, m_instr, m_ipc;
  logic        m_valid, m_mis, m_boot;
  int compared = 0, mismatched = 0;

  always #5 clk = ~clk;
  // Memory word is its own address, optionally scrambled by key.
  assign imem_rdata = imem_addr ^ key;

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .misalign_err(misalign_err)
`ifdef FETCH_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h13; m_ipc = 32'h0; m_valid = 1'b0; m_mis = 1'b0; m_boot = 1'b1;
`ifdef FETCH_PERF_EN
    m_scnt = 0; m_fcnt = 0;
`endif
  endtask

  task automatic check_all();
    chk("imem_addr", imem_addr, m_pc);
    chk("instr", instr, m_instr);
    chk("instr_pc", instr_pc, m_ipc);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
    chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
`ifdef FETCH_PERF_EN
    chk("stall_cnt", stall_cnt, m_scnt);
    chk("flush_cnt", flush_cnt, m_fcnt);
`endif
  endtask

  task automatic cycle(input logic s, input logic r, input logic [31:0] rpc);
    stall = s; redirect = r; redirect_pc = rpc;
    @(posedge clk);
    if (r) begin
      m_pc = {rpc[31:2], 2'b00}; m_instr = 32'h13; m_valid = 1'b0;
      m_mis = m_mis | (rpc[1:0] != 2'b00); m_boot = 1'b0;
    end else if (m_boot) m_boot = 1'b0;
    else if (!s) begin
      m_instr = m_pc ^ key; m_ipc = m_pc; m_valid = 1'b1; m_pc = m_pc + 4;
    end
`ifdef FETCH_PERF_EN
    if (r) m_fcnt++;
    else if (s) m_scnt++;
`endif
    #1 check_all();
  endtask

  initial begin
    model_reset();
    redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_all();
    cycle(0, 0, 0);
    chk("boot_no_load", {31'd0, instr_valid}, 32'd0);
    repeat (3) cycle(0, 0, 0);
    chk("run_instr8", instr, 32'h8);
    chk("run_addrC", imem_addr, 32'hC);
    repeat (2) cycle(1, 0, 0);
    chk("stall_hold", instr, 32'h8);
    chk("stall_addr", imem_addr, 32'hC);
    cycle(0, 0, 0);
    chk("after_stall", instr, 32'hC);
    cycle(1, 1, 32'h100);
    chk("redir_bubble", instr, 32'h13);
    cycle(0, 0, 0);
    chk("redir_target", instr, 32'h100);
    cycle(0, 1, 32'h203);
    chk("misalign_pc", imem_addr, 32'h200);
    chk("misalign_set", {31'd0, misalign_err}, 32'd1);
    cycle(0, 1, 32'h300);
    cycle(0, 0, 0);
    chk("misalign_sticky", {31'd0, misalign_err}, 32'd1);
    cycle(0, 1, 32'hFFFF_FFF8);
    repeat (2) cycle(0, 0, 0);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
    cycle(1, 0, 0);
    #3 rst = 1'b1;
    #1 model_reset();
    check_all();
    @(posedge clk);
    #1 rst = 1'b0;
    cycle(0, 0, 0);
    chk("boot_again", {31'd0, instr_valid}, 32'd0);
    for (int i = 0; i < 400; i++) begin
      logic s, r;
      logic [31:0] rpc;
      key = (i % 50 < 25) ? 32'd0 : $urandom;
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 7) == 0);
      rpc = $urandom & (($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      cycle(s, r, rpc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the RV32 pipeline. It holds the PC, reads instruction memory, and drives the IF/ID register that feeds the instruction decoder. It is the fetch-side end of the decoder's control interface. It consumes the decoder's `stall` request (load-use hold) and the EX-stage branch/jump `redirect`, and it squashes wrong-path fetches by injecting NOP bubbles.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `NOP_INSTR`, 32'h0000_0013, bubble word (`addi x0,x0,0`) injected into IF/ID.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_addr`  out  32  fetch address; equal to the PC register (combinational).
- `imem_rdata`  in  32  instruction word; combinational read of `imem_addr` within the same cycle.
- `stall`  in  1  decoder hold request; freeze PC and IF/ID.
- `redirect`  in  1  taken branch/jump from EX.
- `redirect_pc`  in  32  target address, sampled when `redirect`=1.
- `instr`  out  32  IF/ID instruction to the decoder.
- `instr_pc`  out  32  PC of `instr`.
- `instr_valid`  out  1  `instr` is a real fetched instruction (0 = bubble).
- `misalign_err`  out  1  sticky flag: a redirect target had `[1:0]`≠0.
- `stall_cnt`, `flush_cnt`  out  32 each  performance counters; present only with `FETCH_PERF_EN`.

## Operation
- FSM states: BOOT, RUN, HOLD. Reset enters BOOT.
- BOOT lasts one cycle after reset release:
  - no IF/ID load and PC held; next state is RUN.
  - If `redirect` is asserted in BOOT, it is applied as in RUN and the next state is RUN.
- RUN, no stall, no redirect:
  - `instr`<=`imem_rdata`, `instr_pc`<=PC, `instr_valid`<=1, PC<=PC+4.
- `stall`=1 (in RUN or HOLD), no redirect:
  - PC, `instr`, `instr_pc` and `instr_valid` hold their values.
  - State goes to HOLD, and stays in HOLD while `stall`=1.
  - When `stall` drops, return to RUN; the fetch resumes that same cycle.
- Redirect, in any state, has priority over `stall`:
  - PC<=`{redirect_pc[31:2],2'b00}`.
  - `instr`<=`NOP_INSTR` and `instr_valid`<=0; `instr_pc` holds.
  - Next state is RUN.
- Misalignment: if `redirect_pc[1:0]`≠0 on an accepted redirect, `misalign_err`<=1. It stays set until reset.
- Arithmetic: PC+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000. Only word-aligned PCs are ever produced.
- Reset asserted mid-operation immediately forces every register to its reset value, independent of the clock.

## Timing
- Reset values:
  - PC and `instr_pc` = `RESET_PC`
  - `instr` = `NOP_INSTR`
  - `instr_valid`, `misalign_err` = 0
  - counters = 0
  - `imem_addr` = `RESET_PC`
- After reset falls, the first edge is BOOT. The instruction at `RESET_PC` appears on `instr`, with `instr_valid`=1, after the second edge.
- Fetch latency: one edge from `imem_addr` to `instr`. Throughput is one instruction per cycle while unstalled.
- Redirect: a bubble appears on `instr` after the redirect edge. The target instruction appears one edge later, so the branch penalty at IF/ID is 1 bubble.
- Stall: it is sampled at the edge and freezes that same edge. An N-cycle stall holds `instr` for N+1 cycles total.
- `stall` and `redirect` must be valid before the rising edge. No combinational path runs from `stall` or `redirect` to any output.

## Configuration
- `FETCH_PERF_EN` defined:
  - `stall_cnt` increments on each edge with `stall`=1 and no redirect.
  - `flush_cnt` increments on each accepted redirect.
  - Both wrap at 2^32 and are cleared by reset.
- `FETCH_PERF_EN` undefined: the counter ports and their logic are absent; all other behaviour is identical.

## Test plan
- Reset, then free-run with memory word = address:
  - BOOT for one cycle.
  - Then `instr` = 0, 4, 8, … with `instr_valid`=1.
  - `instr_pc` matches `instr` on every cycle.
- `stall`=1 for 2 cycles while `instr`=0x8:
  - `instr` stays 0x8 and `imem_addr` stays 0xC for 3 cycles.
  - The next value is 0xC.
  - `stall_cnt`=2 when `FETCH_PERF_EN` is defined.
- `redirect`=1, `redirect_pc`=0x100, asserted together with `stall`=1:
  - Next `instr`=0x13 with `instr_valid`=0.
  - Then `instr`=0x100.
  - `flush_cnt`=1.
- `redirect_pc`=0x203:
  - PC becomes 0x200 and `misalign_err`=1.
  - `misalign_err` stays 1 through later normal redirects until `rst`.
- PC=0xFFFF_FFFC in RUN: the next `imem_addr`=0x0000_0000.
- `rst` pulsed asynchronously mid-stall:
  - All outputs take their reset values immediately, without waiting for a clock edge.
  - The FSM restarts in BOOT.
